// File: rtl/gpio_funcs_pipe.sv
// rtl/gpio_funcs_pipe.sv - Per-transaction add/sub/invert/reverse datapath feeding a small result FIFO.
module gpio_funcs_pipe #(
    parameter int DW    = 8,
    parameter int EW    = 128,
    parameter int ADD_K = 12,
    parameter int SUB_K = 34,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 mode,
    input  logic [DW-1:0]              a,
    input  logic [DW-1:0]              b,
    input  logic [EW-1:0]              e,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              c,
    output logic [DW-1:0]              d,
    output logic [EW-1:0]              f,
    output logic [EW-1:0]              g,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DW-1:0] ADD_KV = DW'(ADD_K);
    localparam logic [DW-1:0] SUB_KV = DW'(SUB_K);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [DW-1:0] c_mem [DEPTH];
    logic [DW-1:0] d_mem [DEPTH];
    logic [EW-1:0] f_mem [DEPTH];
    logic [EW-1:0] g_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;
    logic [DW-1:0] c_nxt;
    logic [DW-1:0] d_nxt;
    logic [EW-1:0] g_rev;
    logic [EW-1:0] g_nxt;

    assign in_ready  = (level < DEPTH_L);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The extra MSB of the widened sum/difference is the carry/borrow used for saturation.
    assign sum_w = {1'b0, a} + {1'b0, ADD_KV};
    assign dif_w = {1'b0, b} - {1'b0, SUB_KV};
    assign c_nxt = (mode[0] && sum_w[DW]) ? {DW{1'b1}} : sum_w[DW-1:0];
    assign d_nxt = (mode[0] && dif_w[DW]) ? {DW{1'b0}} : dif_w[DW-1:0];

    always_comb begin
        g_rev = '0;
        for (int i = 0; i < EW; i++) begin
            g_rev[i] = e[EW-1-i];
        end
    end

    assign g_nxt = mode[1] ? g_rev : ~e;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                c_mem[i] <= '0;
                d_mem[i] <= '0;
                f_mem[i] <= '0;
                g_mem[i] <= '0;
            end
        end else if (push) begin
            c_mem[wr_ptr] <= c_nxt;
            d_mem[wr_ptr] <= d_nxt;
            f_mem[wr_ptr] <= e;
            g_mem[wr_ptr] <= g_nxt;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (pop) begin
            count <= count + 16'd1;
        end
    end

    assign c = c_mem[rd_ptr];
    assign d = d_mem[rd_ptr];
    assign f = f_mem[rd_ptr];
    assign g = g_mem[rd_ptr];

endmodule

// File: tb/tb_gpio_funcs_pipe.sv
// tb/tb_gpio_funcs_pipe.sv - Randomized scoreboard bench for gpio_funcs_pipe.
module tb_gpio_funcs_pipe;

    localparam int DW    = 8;
    localparam int EW    = 128;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [EW-1:0] e;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [EW-1:0] f;
    logic [EW-1:0] g;
    logic [LW-1:0] level;
    logic [15:0]   count;

    gpio_funcs_pipe #(
        .DW(DW), .EW(EW), .ADD_K(12), .SUB_K(34), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .e(e),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .d(d), .f(f), .g(g),
        .level(level), .count(count)
    );

    typedef struct {
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        logic [EW-1:0] f;
        logic [EW-1:0] g;
    } res_t;

    res_t        q[$];
    int unsigned m_count;
    int          n_vec;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t model(input logic [1:0] m, input logic [DW-1:0] aa,
                                   input logic [DW-1:0] bb, input logic [EW-1:0] ee);
        res_t r;
        int s;
        int t;
        s = int'(aa) + 12;
        t = int'(bb) - 34;
        r.c = m[0] ? DW'((s > 255) ? 255 : s) : DW'(s % 256);
        r.d = m[0] ? DW'((t < 0) ? 0 : t) : DW'((t + 256) % 256);
        r.f = ee;
        if (m[1]) begin
            for (int i = 0; i < EW; i++) r.g[i] = ee[EW-1-i];
        end else begin
            r.g = ~ee;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            q.delete();
            m_count = 0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = out_ready && (q.size() != 0);
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) begin
                void'(q.pop_front());
                m_count = (m_count + 1) % 65536;
            end
            if (do_push) q.push_back(model(mode, a, b, e));
        end
    end

    always @(negedge clk) begin
        if (nreset) begin
            check("out_valid", EW'(out_valid), EW'(q.size() != 0));
            check("in_ready", EW'(in_ready), EW'(q.size() < DEPTH));
            check("level", EW'(level), EW'(q.size()));
            check("count", EW'(count), EW'(m_count));
            if (q.size() != 0) begin
                check("c", EW'(c), EW'(q[0].c));
                check("d", EW'(d), EW'(q[0].d));
                check("f", f, q[0].f);
                check("g", g, q[0].g);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [DW-1:0] aa,
                         input logic [DW-1:0] bb, input logic [EW-1:0] ee);
        in_valid = v;
        mode     = m;
        a        = aa;
        b        = bb;
        e        = ee;
    endtask

    task automatic rand_data();
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
              8'($urandom), {$urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        logic [EW-1:0] top_bit;
        n_vec   = 0;
        n_err   = 0;
        m_count = 0;
        nreset  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0);
        #1;
        check("rst_out_valid", EW'(out_valid), '0);
        check("rst_in_ready", EW'(in_ready), EW'(1));
        check("rst_level", EW'(level), '0);
        check("rst_count", EW'(count), '0);
        check("rst_c", EW'(c), '0);
        check("rst_d", EW'(d), '0);
        check("rst_f", f, '0);
        check("rst_g", g, '0);
        @(posedge clk);
        #2 nreset = 1'b1;

        // Wrap-around arithmetic; push into empty buffer with out_ready high is not popped.
        drive(1'b1, 2'b00, 8'd250, 8'd10, 128'h0F);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("wrap_valid", EW'(out_valid), EW'(1));
        check("wrap_c", EW'(c), EW'(6));
        check("wrap_d", EW'(d), EW'(232));
        check("wrap_f", f, 128'h0F);
        check("wrap_g", g, ~128'h0F);
        step();
        check("wrap_count", EW'(count), EW'(1));
        check("wrap_drained", EW'(out_valid), '0);

        drive(1'b1, 2'b01, 8'd250, 8'd10, 128'h0);
        step();
        check("sat_hi_c", EW'(c), EW'(255));
        check("sat_lo_d", EW'(d), '0);
        drive(1'b1, 2'b01, 8'd3, 8'd40, 128'h0);
        step();
        check("sat_mid_c", EW'(c), EW'(15));
        check("sat_mid_d", EW'(d), EW'(6));
        in_valid = 1'b0;
        step();

        drive(1'b1, 2'b10, 8'd0, 8'd0, 128'h1);
        step();
        in_valid = 1'b0;
        top_bit = '0;
        top_bit[EW-1] = 1'b1;
        check("rev_g", g, top_bit);
        check("rev_f", f, 128'h1);
        step();

        // Back-pressure to full, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_data();
            in_valid = 1'b1;
            step();
        end
        check("full_in_ready", EW'(in_ready), '0);
        check("full_level", EW'(level), EW'(DEPTH));
        rand_data();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("after_pop_in_ready", EW'(in_ready), EW'(1));
        check("after_pop_level", EW'(level), EW'(DEPTH - 1));
        in_valid = 1'b0;
        repeat (DEPTH + 1) step();

        for (int i = 0; i < 1500; i++) begin
            nreset    = (i == 700) ? 1'b0 : 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            rand_data();
            step();
        end
        nreset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();

        // Known state: count=5 and buffer full, then asynchronous reset.
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            in_valid  = 1'b1;
            out_ready = 1'b0;
            step();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_data();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_count", EW'(count), EW'(5));
        check("pre_rst_level", EW'(level), EW'(DEPTH));
        #1 nreset = 1'b0;
        #1;
        check("async_out_valid", EW'(out_valid), '0);
        check("async_level", EW'(level), '0);
        check("async_count", EW'(count), '0);
        check("async_in_ready", EW'(in_ready), EW'(1));
        check("async_c", EW'(c), '0);
        step();
        nreset = 1'b1;

        // Streaming push+pop every cycle to wrap the delivery counter.
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            rand_data();
            in_valid = 1'b1;
            step();
        end
        check("count_ffff", EW'(count), EW'(16'hFFFF));
        step();
        check("count_wrap", EW'(count), '0);
        in_valid = 1'b0;
        repeat (DEPTH + 1) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
